// File: rtl/samplerz_pkg.sv
// Shared SamplerZ constants and types.
// Used by ber_exp_cmp and the SamplerZ controller.
package samplerz_pkg;

    localparam int unsigned ZW     = 64;  // width of the BerExp comparison word z
    localparam int unsigned BYTE_W = 8;   // random byte width
    localparam int unsigned NBYTES = 8;   // bytes per z word
    localparam int unsigned IDX_W  = $clog2(NBYTES);
    localparam int unsigned SH_W   = $clog2(ZW);

    typedef enum logic [1:0] {
        StIdle,
        StCmp,
        StDone
    } ber_state_t;

endpackage

// File: rtl/shr64.sv
// Combinational 64-bit logical right barrel shifter.
// Ports:
//   din  - value to shift
//   amt  - shift amount, 0..63
//   dout - din >> amt, zero filled
module shr64
    import samplerz_pkg::*;
(
    input  logic [ZW-1:0]   din,
    input  logic [SH_W-1:0] amt,
    output logic [ZW-1:0]   dout
);

    // One stage per amount bit; stage i shifts by 2**i.
    always_comb begin
        logic [ZW-1:0] v;
        v = din;
        for (int i = 0; i < int'(SH_W); i++) begin
            if (amt[i]) begin
                v = v >> (1 << i);
            end
        end
        dout = v;
    end

endmodule

// File: rtl/ber_exp_cmp.sv
// BerExp accept/reject stage of the SamplerZ exponential loop.
// Forms z = ((2*y_63) - 1) >> s_in on start, then compares z against uniform
// random bytes MSB byte first and reports a single accept bit.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - one-cycle pulse, samples y_63 and s_in when idle
//   y_63, s_in    - polynomial result and shift amount
//   rnd_req       - high while a random byte is wanted
//   rnd_valid     - random byte available; consumed when rnd_req is also high
//   rnd_byte      - uniform random byte
//   busy          - comparison in progress, up to and including result_valid
//   result_valid  - one-cycle result pulse
//   accept        - result, held until the next result_valid
module ber_exp_cmp
    import samplerz_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [62:0]       y_63,
    input  logic [SH_W-1:0]   s_in,
    output logic              rnd_req,
    input  logic              rnd_valid,
    input  logic [BYTE_W-1:0] rnd_byte,
    output logic              busy,
    output logic              result_valid,
    output logic              accept
);

    ber_state_t        state_q, state_d;
    logic [ZW-1:0]     z_q, z_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              accept_q, accept_d;

    logic [ZW-1:0]     z_pre;
    logic [ZW-1:0]     z_shifted;
    logic [BYTE_W-1:0] zb;

    // Modulo 2^64: y_63 = 0 wraps to all ones.
    assign z_pre = {y_63, 1'b0} - 64'd1;

    shr64 u_shr64 (
        .din  (z_pre),
        .amt  (s_in),
        .dout (z_shifted)
    );

    assign zb = z_q[idx_q*BYTE_W +: BYTE_W];

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        idx_d    = idx_q;
        accept_d = accept_q;
        rnd_req  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    z_d     = z_shifted;
                    idx_d   = IDX_W'(NBYTES - 1);
                    state_d = StCmp;
                end
            end
            StCmp: begin
                rnd_req = 1'b1;
                if (rnd_valid) begin
                    if (rnd_byte < zb) begin
                        accept_d = 1'b1;
                        state_d  = StDone;
                    end else if (rnd_byte > zb) begin
                        accept_d = 1'b0;
                        state_d  = StDone;
                    end else if (idx_q == '0) begin
                        // All bytes equal: w == z is not w < z.
                        accept_d = 1'b0;
                        state_d  = StDone;
                    end else begin
                        idx_d = idx_q - 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            z_q      <= '0;
            idx_q    <= IDX_W'(NBYTES - 1);
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            idx_q    <= idx_d;
            accept_q <= accept_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign accept       = accept_q;

endmodule

// File: tb/tb_ber_exp_cmp.sv
// Self-checking bench for ber_exp_cmp with an expected-result scoreboard.
module tb_ber_exp_cmp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [62:0] y_63 = '0;
    logic [5:0]  s_in = '0;
    logic        rnd_req;
    logic        rnd_valid = 1'b0;
    logic [7:0]  rnd_byte = '0;
    logic        busy;
    logic        result_valid;
    logic        accept;

    ber_exp_cmp dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .y_63         (y_63),
        .s_in         (s_in),
        .rnd_req      (rnd_req),
        .rnd_valid    (rnd_valid),
        .rnd_byte     (rnd_byte),
        .busy         (busy),
        .result_valid (result_valid),
        .accept       (accept)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic acc;
        int   lat;
        int   nb;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   consumed = 0;
    bit   armed = 1'b0;
    logic last_acc = 1'b0;

    localparam logic [62:0] Y1 = 63'h4000_0000_0000_0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: outputs sampled on the falling edge, results popped from the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rnd_req && rnd_valid) consumed++;
            if (armed) begin
                check("busy_active", busy, 1);
                if (result_valid) begin
                    if (sb.size() == 0) begin
                        check("rv_unexpected", result_valid, 0);
                    end else begin
                        e_mon = sb.pop_front();
                        check("accept", accept, e_mon.acc);
                        // Latency counted in edges from the start edge to DONE.
                        check("latency", cyc - start_cyc, e_mon.lat);
                        check("bytes_consumed", consumed, e_mon.nb);
                        last_acc = e_mon.acc;
                    end
                    armed = 1'b0;
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_req", rnd_req, 0);
                check("idle_rv", result_valid, 0);
                check("accept_hold", accept, last_acc);
            end
        end
    end

    // ign: index of the stimulus cycle carrying a stray start (-1 for none).
    task automatic run(input logic [62:0] y, input logic [5:0] s, input logic [7:0] b[8],
                       input int n, input int stalls, input int ign, input logic exp_acc);
        exp_t e;
        e.acc = exp_acc;
        e.lat = n + stalls;
        e.nb  = n;
        sb.push_back(e);
        @(posedge clk); #2;
        start = 1'b1; y_63 = y; s_in = s; rnd_valid = 1'b0;
        @(posedge clk); #1;
        start_cyc = cyc; consumed = 0; armed = 1'b1;
        #1;
        for (int i = 0; i < stalls + n; i++) begin
            start = (i == ign);
            if (i == ign) begin
                y_63 = '0;
                s_in = 6'd63;
            end
            if (i >= stalls) begin
                rnd_valid = 1'b1;
                rnd_byte  = b[i - stalls];
            end else begin
                rnd_valid = 1'b0;
                rnd_byte  = 8'hA5;
            end
            @(posedge clk); #2;
        end
        start = 1'b0; rnd_valid = 1'b0;
        for (int t = 0; t < 40 && armed; t++) @(posedge clk);
        if (armed) begin
            check("timeout", 1, 0);
            armed = 1'b0;
            sb.delete();
        end
    endtask

    task automatic model(input logic [63:0] z, input logic [7:0] b[8],
                         output logic acc, output int n);
        acc = 1'b0;
        n   = 8;
        for (int j = 0; j < 8; j++) begin
            logic [7:0] zb;
            zb = z[8*(7-j) +: 8];
            if (b[j] < zb) begin
                acc = 1'b1; n = j + 1; break;
            end else if (b[j] > zb) begin
                acc = 1'b0; n = j + 1; break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bv[8];
        logic [63:0] r;
        logic [63:0] z;
        logic        acc;
        int          n;

        repeat (3) @(posedge clk);
        #2;
        check("rst_req", rnd_req, 0);
        check("rst_busy", busy, 0);
        check("rst_rv", result_valid, 0);
        check("rst_accept", accept, 0);
        rst_n = 1'b1;

        // z = 7FFF_FFFF_FFFF_FFFF
        bv = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(Y1, 6'd0, bv, 1, 0, -1, 1'b1);
        bv = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(Y1, 6'd0, bv, 1, 0, -1, 1'b0);
        bv = '{8'h7F, 8'hFF, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(Y1, 6'd0, bv, 3, 0, -1, 1'b1);
        bv = '{8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run(Y1, 6'd0, bv, 8, 0, -1, 1'b0);

        // y=0, s=4: z = 0FFF_FFFF_FFFF_FFFF; stray start (z would be 1) must be ignored.
        bv = '{8'h0E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(63'd0, 6'd4, bv, 1, 3, 1, 1'b1);

        // s=63: z = 0 for Y1, z = 1 for y=0.
        bv = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(Y1, 6'd63, bv, 1, 0, -1, 1'b0);
        bv = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(63'd0, 6'd63, bv, 8, 0, -1, 1'b1);

        // Reset mid-comparison: no result, all outputs cleared.
        @(posedge clk); #2;
        start = 1'b1; y_63 = Y1; s_in = 6'd63;
        @(posedge clk); #1;
        start_cyc = cyc; consumed = 0; armed = 1'b1;
        #1;
        start = 1'b0; rnd_valid = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rnd_valid = 1'b1; rnd_byte = 8'h10;
        rst_n = 1'b0; armed = 1'b0;
        #1;
        check("midrst_req", rnd_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_rv", result_valid, 0);
        check("midrst_accept", accept, 0);
        @(posedge clk); #2;
        check("midrst_rv2", result_valid, 0);
        last_acc = 1'b0;
        rnd_valid = 1'b0;
        rst_n = 1'b1;

        bv = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run(Y1, 6'd0, bv, 1, 0, -1, 1'b1);

        // Random transactions checked against a reference model.
        for (int k = 0; k < 8; k++) begin
            logic [62:0] y;
            logic [5:0]  s;
            r = {$urandom(), $urandom()};
            y = r[62:0];
            s = 6'($urandom_range(0, 12));
            z = ({y, 1'b0} - 64'd1) >> s;
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 3) != 0) bv[j] = z[8*(7-j) +: 8];
                else bv[j] = 8'($urandom());
            end
            model(z, bv, acc, n);
            run(y, s, bv, n, $urandom_range(0, 2), -1, acc);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ber_exp_cmp.md
# ber_exp_cmp

Downstream stage of the SamplerZ exponential-approximation loop. It takes the 63-bit polynomial result `y_63` and the shift amount `s`, and forms `z = ((2·y_63) − 1) >> s` as a 64-bit value. It then runs the Falcon BerExp lazy byte-wise comparison of `z` against uniform random bytes, MSB byte first, and returns a single accept/reject bit to the SamplerZ controller.

## Interface
Parameters: none. Shared constants are in `samplerz_pkg`.

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; driven by the upstream loop `done`
- y_63  in  63  ApproxExp result, sampled on `start`
- s_in  in  6  shift amount, already clamped to ≤63 upstream; sampled on `start`
- rnd_req  out  1  request for a random byte
- rnd_valid  in  1  random byte available
- rnd_byte  in  8  uniform random byte
- busy  out  1  high from the cycle after `start` until the cycle `result_valid` is asserted, inclusive
- result_valid  out  1  one-cycle pulse
- accept  out  1  BerExp result; valid with `result_valid`, held until the next `result_valid`

## Operation
- FSM states: IDLE, CMP, DONE. Encoded as enum `ber_state_t`.
- **IDLE, `start`=1:**
  - Register `z <= ({y_63,1'b0} − 64'd1) >> s_in`. The subtraction is modulo 2^64, so `y_63`=0 gives `z` = all ones before the shift.
  - `idx <= 3'd7`, the byte index.
  - Go to CMP.
- **IDLE, `start`=0:** hold state.
- **CMP:**
  - `rnd_req`=1.
  - A byte is consumed only when `rnd_req && rnd_valid`.
  - Let `zb = z[8·idx+7 : 8·idx]`.
  - `rnd_byte < zb`: `accept_n` = 1, go to DONE.
  - `rnd_byte > zb`: `accept_n` = 0, go to DONE.
  - Equal and `idx` ≠ 0: `idx` decrements, stay in CMP.
  - Equal and `idx` = 0: `accept_n` = 0 (w = 0 is treated as not < 0), go to DONE.
  - `rnd_valid`=0: hold state, `idx`, and `z`.
- **DONE:**
  - `result_valid`=1 for exactly one cycle.
  - `accept` is registered from `accept_n`.
  - Return to IDLE.
- `start` in CMP or DONE is ignored; no queuing.
- `rnd_req` is 0 outside CMP. Bytes offered while `rnd_req`=0 are not consumed.

## Timing
- `start` at edge T → CMP with `z` valid at T+1.
- With `rnd_valid` continuously high and a decision on byte k (k = 1..8): `result_valid` at T+1+k.
  - Best case is T+2.
  - Worst case is T+9.
- Each `rnd_valid`-low cycle in CMP adds one cycle.
- Back-to-back: the earliest next `start` accepted is the IDLE cycle after DONE, i.e. one cycle after `result_valid`.
- Reset values:
  - state IDLE, `z` 0, `idx` 7
  - `rnd_req` 0, `busy` 0, `result_valid` 0, `accept` 0
- Reset asserted mid-comparison aborts immediately. No `result_valid` is produced, and the random byte in flight is dropped.
- `s_in`=63 leaves `z` ≤ 1, so bytes 7..1 are 0. Any nonzero first byte rejects, and only an all-zero byte sequence plus a byte-0 value below `z[7:0]` can accept.

## Structure
- `samplerz_pkg`: `ber_state_t`, `ZW`=64, `BYTE_W`=8, `NBYTES`=8. Shared with the SamplerZ controller.
- One sub-module, `shr64`: combinational 64-bit logical right barrel shifter (6-bit amount), used for the `z` computation. Reusable for the SamplerZ `s` handling.
- FSM, byte mux, and comparator stay in `ber_exp_cmp`.

## Test plan
- `y_63`=63'h4000_0000_0000_0000, `s_in`=0 → `z`=64'h7FFF_FFFF_FFFF_FFFF. Rnd 0x10 at T+1 → `result_valid` at T+2, `accept`=1, exactly one byte consumed.
- Same inputs, rnd 0x80 → `accept`=0 at T+2.
- Same inputs, rnd 0x7F, 0xFF, 0x12 → `accept`=1 at T+4, three bytes consumed.
- Same inputs, rnd sequence equal to all 8 bytes of `z` → `accept`=0 at T+9, `rnd_req` low afterwards.
- `y_63`=0, `s_in`=4 → `z`=64'h0FFF_FFFF_FFFF_FFFF. `rnd_valid` low for 3 cycles, then 0x0E → `accept`=1 at T+5, `busy` high throughout. A second `start` pulse at T+2 is ignored.
- `s_in`=63, `y_63`=63'h4000_0000_0000_0000 → `z`=0. Rnd 0x01 → `accept`=0. In a second run, assert `rst_n` low at T+3 mid-CMP → all outputs 0 and no `result_valid`. A new `start` after reset runs normally.
